// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester arbiter in front of a single-port RAM, one access per 3 cycles.
// Define RAM_ARB_RR_EN for round-robin tie breaking; otherwise req0 has fixed priority.
module ram_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [7:0]  addr0,
  input  logic [7:0]  addr1,
  input  logic [63:0] wdata0,
  input  logic [63:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [63:0] rdata0,
  output logic [63:0] rdata1,
  output logic        busy,
  output logic        cen,
  output logic        wen,
  output logic [7:0]  s_addr,
  output logic [63:0] s_din,
  input  logic [63:0] s_dout
);
  typedef enum logic [1:0] {IDLE, CMD, RSP} state_t;
  state_t state;
  logic win, sel_we, op_k, op_we;
`ifdef RAM_ARB_RR_EN
  logic last;
  assign win = (req0 && req1) ? ~last : req1;
`else
  assign win = ~req0;
`endif
  assign sel_we = win ? we1 : we0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
      busy    <= 1'b0;
      cen     <= 1'b0;
      wen     <= 1'b0;
      s_addr  <= '0;
      s_din   <= '0;
      op_k    <= 1'b0;
      op_we   <= 1'b0;
`ifdef RAM_ARB_RR_EN
      last    <= 1'b1;
`endif
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      cen     <= 1'b0;
      wen     <= 1'b0;
      case (state)
        IDLE: if (req0 || req1) begin
          state  <= CMD;
          busy   <= 1'b1;
          cen    <= 1'b1;
          wen    <= sel_we;
          s_addr <= win ? addr1 : addr0;
          s_din  <= sel_we ? (win ? wdata1 : wdata0) : 64'h0;
          gnt0   <= ~win;
          gnt1   <= win;
          op_k   <= win;
          op_we  <= sel_we;
`ifdef RAM_ARB_RR_EN
          last   <= win;
`endif
        end
        CMD: state <= RSP;
        RSP: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!op_we && !op_k) begin
            rvalid0 <= 1'b1;
            rdata0  <= s_dout;
          end
          if (!op_we && op_k) begin
            rvalid1 <= 1'b1;
            rdata1  <= s_dout;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and random checks of ram_arbiter against a transaction-level model.
module tb_ram_arbiter;
  logic clk = 0, rst = 1, req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [7:0] addr0 = 0, addr1 = 0;
  logic [63:0] wdata0 = 0, wdata1 = 0, s_dout = 0;
  logic gnt0, gnt1, rvalid0, rvalid1, busy, cen, wen;
  logic [63:0] rdata0, rdata1, s_din;
  logic [7:0] s_addr;
  logic [63:0] ram [256];
  logic [63:0] mm [256];
  int checks = 0, errors = 0, t = 0, free_at = 0, rv_at = -1;
  logic rv_k;
  logic [63:0] rv_d;
`ifdef RAM_ARB_RR_EN
  logic last = 1;
`endif
  logic e_gnt0, e_gnt1, e_rv0, e_rv1, e_busy, e_cen, e_wen;
  logic [63:0] e_rd0, e_rd1, e_din;
  logic [7:0] e_addr;
  int order [4];
  int n;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .busy(busy), .cen(cen), .wen(wen),
    .s_addr(s_addr), .s_din(s_din), .s_dout(s_dout)
  );

  always @(posedge clk)
    if (cen) begin
      if (wen) ram[s_addr] <= s_din;
      else s_dout <= ram[s_addr];
    end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // A grant at edge t blocks the next one until t+3 and returns read data after edge t+2.
  task automatic step;
    logic k;
    @(posedge clk);
    t++;
    e_gnt0 = 0; e_gnt1 = 0; e_rv0 = 0; e_rv1 = 0; e_cen = 0; e_wen = 0;
    if (rst) begin
      free_at = t + 1; rv_at = -1;
      e_addr = 0; e_din = 0; e_rd0 = 0; e_rd1 = 0;
`ifdef RAM_ARB_RR_EN
      last = 1;
`endif
    end else begin
      if (rv_at == t) begin
        if (rv_k) begin e_rv1 = 1; e_rd1 = rv_d; end
        else begin e_rv0 = 1; e_rd0 = rv_d; end
      end
      if (t >= free_at && (req0 || req1)) begin
`ifdef RAM_ARB_RR_EN
        k = (req0 && req1) ? !last : req1;
        last = k;
`else
        k = !req0;
`endif
        e_gnt0 = !k; e_gnt1 = k; e_cen = 1;
        e_wen = k ? we1 : we0;
        e_addr = k ? addr1 : addr0;
        if (e_wen) begin
          e_din = k ? wdata1 : wdata0;
          mm[e_addr] = e_din;
        end else begin
          e_din = 0; rv_at = t + 2; rv_k = k; rv_d = mm[e_addr];
        end
        free_at = t + 3;
      end
    end
    e_busy = (t + 1 < free_at);
    #1;
    chk("gnt0", gnt0, e_gnt0);
    chk("gnt1", gnt1, e_gnt1);
    chk("rvalid0", rvalid0, e_rv0);
    chk("rvalid1", rvalid1, e_rv1);
    chk("rdata0", rdata0, e_rd0);
    chk("rdata1", rdata1, e_rd1);
    chk("busy", busy, e_busy);
    chk("cen", cen, e_cen);
    chk("wen", wen, e_wen);
    chk("s_addr", s_addr, e_addr);
    chk("s_din", s_din, e_din);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = {$urandom, $urandom};
      mm[i] = ram[i];
    end
    ram[8'h10] = 64'hA5A5_0000_1234_5678;
    mm[8'h10] = 64'hA5A5_0000_1234_5678;
    step; step;
    rst = 0;
    // single read
    req0 = 1; we0 = 0; addr0 = 8'h10;
    step;
    chk("rd_gnt0", gnt0, 1);
    chk("rd_busy1", busy, 1);
    req0 = 0;
    step;
    chk("rd_busy2", busy, 1);
    step;
    chk("rd_rvalid0", rvalid0, 1);
    chk("rd_data0", rdata0, 64'hA5A5_0000_1234_5678);
    // write then read on requester 1
    req1 = 1; we1 = 1; addr1 = 8'h20; wdata1 = 64'hDEAD_BEEF_0000_0001;
    step;
    chk("wr_gnt1", gnt1, 1);
    req1 = 0;
    step; step;
    chk("wr_no_rvalid1", rvalid1, 0);
    req1 = 1; we1 = 0;
    step;
    req1 = 0;
    step; step;
    chk("wr_rd_rvalid1", rvalid1, 1);
    chk("wr_rd_data1", rdata1, 64'hDEAD_BEEF_0000_0001);
    // sustained tie
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 8'h01; addr1 = 8'h02;
    n = 0;
    order = '{default: 9};
    for (int i = 0; i < 12; i++) begin
      step;
      if ((gnt0 || gnt1) && n < 4) begin order[n] = gnt1 ? 1 : 0; n++; end
    end
`ifdef RAM_ARB_RR_EN
    chk("tie0", order[0], 0); chk("tie1", order[1], 1);
    chk("tie2", order[2], 0); chk("tie3", order[3], 1);
`else
    chk("tie0", order[0], 0); chk("tie1", order[1], 0);
    chk("tie2", order[2], 0); chk("tie3", order[3], 0);
`endif
    req0 = 0;
    for (int i = 0; i < 3; i++) step;
    req1 = 0;
    for (int i = 0; i < 3; i++) step;
    // reset during RSP of a read
    req0 = 1; we0 = 0; addr0 = 8'h10;
    step;
    req0 = 0;
    step;
    rst = 1;
    step;
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_busy", busy, 0);
    rst = 0;
    step;
    chk("post_rst_rvalid0", rvalid0, 0);
    req0 = 1; req1 = 1;
    step;
    chk("post_rst_tie_gnt0", gnt0, 1);
    chk("post_rst_tie_gnt1", gnt1, 0);
    // random traffic
    for (int i = 0; i < 1500; i++) begin
      if (e_gnt0) req0 = 0;
      if (e_gnt1) req1 = 0;
      if (!req0 && $urandom_range(2) == 0) begin
        req0 = 1; we0 = 1'($urandom_range(1)); addr0 = 8'($urandom_range(15)); wdata0 = {$urandom, $urandom};
      end
      if (!req1 && $urandom_range(2) == 0) begin
        req1 = 1; we1 = 1'($urandom_range(1)); addr1 = 8'($urandom_range(15)); wdata1 = {$urandom, $urandom};
      end
      rst = ($urandom_range(150) == 0);
      step;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 req0, req1  input  1 each  access request per requester; held until the matching gnt is seen.
REQ-004 we0, we1  input  1 each  1 = write, 0 = read; sampled with the request.
REQ-005 addr0, addr1  input  8 each  word address.
REQ-006 wdata0, wdata1  input  64 each  write data.
REQ-007 gnt0, gnt1  output  1 each  registered one-cycle pulse: command accepted.
REQ-008 rvalid0, rvalid1  output  1 each  registered one-cycle pulse: read data valid.
REQ-009 rdata0, rdata1  output  64 each  read data; holds until the next read for that requester.
REQ-010 busy  output  1  high in states CMD and RSP.
REQ-011 cen, wen  output  1 each  RAM chip enable and write enable, registered.
REQ-012 s_addr  output  8  RAM address, registered.
REQ-013 s_din  output  64  RAM write data, registered.
REQ-014 s_dout  input  64  RAM read data, valid one cycle after cen=1 with wen=0.

Function
REQ-015 FSM states: IDLE, CMD, RSP; one RAM access per 3 cycles.
REQ-016 IDLE: if any req is high at edge E0, the arbiter selects a winner k and registers cen=1, wen=we_k, s_addr=addr_k, s_din=wdata_k (64'h0 for reads), gnt_k=1, and the pending op (k, we_k), then goes to CMD; otherwise it stays in IDLE with cen=0.
REQ-017 CMD: at E1 the RAM samples the command; the arbiter registers cen=0, wen=0, gnt=0 and goes to RSP.
REQ-018 RSP: at E2, if the op was a read, the arbiter registers rdata_k=s_dout and rvalid_k=1; in all cases it goes to IDLE.
REQ-019 Latency: gnt high in cycle [E0,E1]; rvalid/rdata valid in cycle [E2,E3]; the next grant is possible at E3.
REQ-020 Writes produce gnt only and never assert rvalid.
REQ-021 Only one gnt and only one rvalid may be high in any cycle.
REQ-022 Requests arriving in CMD or RSP are ignored until IDLE; req/we/addr/wdata are sampled only in IDLE.
REQ-023 Arbitration ordering follows REQ-030/REQ-031; a single requester always wins immediately.
REQ-024 cen and wen are never high outside the CMD-state cycle; s_addr and s_din hold their last values when cen=0.

Reset
REQ-025 rst=1 at an edge forces state=IDLE and cen=wen=0.
REQ-026 rst=1 at an edge forces s_addr=0, s_din=0, gnt0=gnt1=0, rvalid0=rvalid1=0, rdata0=rdata1=0, busy=0.
REQ-027 rst=1 at an edge sets the round-robin pointer to last=1, so requester 0 wins the first tie.
REQ-028 Reset in CMD or RSP aborts the access: no rvalid is issued; a write already sampled by the RAM in CMD is not undone.
REQ-029 rst takes priority over every other event in the same cycle.

Configuration
REQ-030 Macro RAM_ARB_RR_EN defined: round-robin arbitration; on a tie the requester not granted last wins; the pointer updates on every grant.
REQ-031 Macro RAM_ARB_RR_EN undefined: fixed priority, req0 always wins a tie; the pointer logic is absent.

Verification
REQ-032 Single read: preload RAM[0x10]=64'hA5A5_0000_1234_5678; req0=1, we0=0, addr0=0x10 -> gnt0 in cycle 1, rvalid0=1 with rdata0=64'hA5A5_0000_1234_5678 in cycle 3, busy high in cycles 1-2.
REQ-033 Write then read: req1 writes 64'hDEAD_BEEF_0000_0001 to 0x20, then req1 reads 0x20 -> gnt1 for the write, no rvalid1 for it, then rvalid1 with rdata1=64'hDEAD_BEEF_0000_0001.
REQ-034 Tie with RAM_ARB_RR_EN defined: req0 and req1 held high for 4 accesses -> grant order 0,1,0,1, gnts 3 cycles apart.
REQ-035 Tie with RAM_ARB_RR_EN undefined: same stimulus -> req0 wins every grant while held; req1 is granted only after req0 drops.
REQ-036 Reset mid-access: assert rst in the RSP cycle of a read of 0x10 -> rvalid0 never pulses, all outputs are 0 the next cycle, and the first tie after reset grants requester 0.
